// File: rtl/bus_dma_reader_if.sv
// rtl/bus_dma_reader_if.sv - processor-bus, grant and output-stream signals of the DMA reader
interface bus_dma_reader_if;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic       bus_req;
    logic       bus_gnt;
    logic [7:0] dma_addr;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output bus_addr, bus_we, bus_gnt, out_ready,
        input  bus_req, dma_addr, out_data, out_valid
    );

    modport slave (
        input  bus_addr, bus_we, bus_gnt, out_ready,
        output bus_req, dma_addr, out_data, out_valid
    );
endinterface

// File: rtl/bus_dma_reader.sv
// rtl/bus_dma_reader.sv - bus-mastering DMA that reads LEN bytes from RAM and streams them out
module bus_dma_reader #(
    parameter logic [7:0] DMABaseAddr = 8'hC0
) (
    input  logic             CLK,
    input  logic             RESET,
    inout  wire  [7:0]       BUS_DATA,
    bus_dma_reader_if.slave  bus
);
    localparam logic [7:0] AddrSrc    = DMABaseAddr;
    localparam logic [7:0] AddrLen    = DMABaseAddr + 8'd1;
    localparam logic [7:0] AddrCtrl   = DMABaseAddr + 8'd2;
    localparam logic [7:0] AddrStatus = DMABaseAddr + 8'd3;

    typedef enum logic [2:0] {IDLE, REQ, RD1, RD2, PUSH} state_t;

    state_t     state, next_state;
    logic [7:0] src, len, cur_addr, count, out_data, dma_addr, status_q;
    logic       done, aborted, status_oe;
    logic       wr_src, wr_len, wr_ctrl, rd_status, start_req, abort_req, busy;

    assign wr_src    = bus.bus_we && (bus.bus_addr == AddrSrc);
    assign wr_len    = bus.bus_we && (bus.bus_addr == AddrLen);
    assign wr_ctrl   = bus.bus_we && (bus.bus_addr == AddrCtrl);
    assign rd_status = !bus.bus_we && (bus.bus_addr == AddrStatus);
    assign abort_req = wr_ctrl && BUS_DATA[1];
    assign start_req = wr_ctrl && BUS_DATA[0] && !BUS_DATA[1];
    assign busy      = (state != IDLE);

    // Only the STATUS read response ever drives the shared bus from this block.
    assign BUS_DATA      = status_oe ? status_q : 8'hzz;
    assign bus.bus_req   = (state == REQ) || (state == RD1) || (state == RD2);
    assign bus.out_valid = (state == PUSH);
    assign bus.out_data  = out_data;
    assign bus.dma_addr  = dma_addr;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start_req && len != 8'd0) next_state = REQ;
            REQ: begin
                if (abort_req)        next_state = IDLE;
                else if (bus.bus_gnt) next_state = RD1;
            end
            RD1: begin
                if (abort_req)         next_state = IDLE;
                else if (!bus.bus_gnt) next_state = REQ;
                else                   next_state = RD2;
            end
            RD2: begin
                if (abort_req)         next_state = IDLE;
                else if (!bus.bus_gnt) next_state = REQ;
                else                   next_state = PUSH;
            end
            PUSH: begin
                if (abort_req)          next_state = IDLE;
                else if (bus.out_ready) next_state = (count == 8'd0) ? IDLE : REQ;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            src       <= 8'd0;
            len       <= 8'd0;
            cur_addr  <= 8'd0;
            count     <= 8'd0;
            out_data  <= 8'd0;
            dma_addr  <= 8'd0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            status_oe <= 1'b0;
            status_q  <= 8'd0;
        end else begin
            // STATUS answers one cycle after the read, like the RAM's registered read.
            status_oe <= rd_status;
            status_q  <= {5'b0, aborted, done, busy};
            dma_addr  <= cur_addr;
            if (state == IDLE) begin
                if (wr_src) src <= BUS_DATA;
                if (wr_len) len <= BUS_DATA;
                if (start_req) begin
                    aborted <= 1'b0;
                    if (len == 8'd0) begin
                        done <= 1'b1;
                    end else begin
                        done     <= 1'b0;
                        cur_addr <= src;
                        count    <= len;
                    end
                end
            end else if (abort_req) begin
                aborted <= 1'b1;
            end else begin
                if (state == RD2 && bus.bus_gnt) begin
                    out_data <= BUS_DATA;
                    cur_addr <= cur_addr + 8'd1;
                    count    <= count - 8'd1;
                end
                if (state == PUSH && bus.out_ready && count == 8'd0) done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bus_dma_reader.sv
// tb/tb_bus_dma_reader.sv - self-checking bench for bus_dma_reader with a RAM model
module tb_bus_dma_reader;
    localparam logic [7:0] Base = 8'hC0;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    wire  [7:0] bus_data;
    logic       cpu_oe = 1'b0;
    logic [7:0] cpu_d = 8'd0;
    logic [7:0] ram [256];
    logic [7:0] ram_q;
    logic       ram_drive;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] got [$];
    int         stamps [$];

    bus_dma_reader_if bus();

    bus_dma_reader #(.DMABaseAddr(Base)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .BUS_DATA (bus_data),
        .bus      (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) ram_q <= ram[bus.bus_gnt ? bus.dma_addr : bus.bus_addr];
    assign ram_drive = bus.bus_gnt && bus.bus_req;
    assign bus_data  = cpu_oe ? cpu_d : (ram_drive ? ram_q : 8'hzz);

    always @(negedge CLK) begin
        if (!RESET && bus.out_valid && bus.out_ready) begin
            got.push_back(bus.out_data);
            stamps.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data);
        bus.bus_addr = addr;
        bus.bus_we   = 1'b1;
        cpu_d        = data;
        cpu_oe       = 1'b1;
        tick();
        bus.bus_we   = 1'b0;
        cpu_oe       = 1'b0;
        bus.bus_addr = 8'h00;
    endtask

    task automatic read_status(output logic [7:0] val);
        bus.bus_gnt  = 1'b0;
        bus.bus_addr = Base + 8'd3;
        bus.bus_we   = 1'b0;
        tick();
        bus.bus_addr = 8'h00;
        val = bus_data;
        tick();
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        check(tag, {31'd0, bus.out_valid}, 32'd1);
    endtask

    // mode 0: grant/ready always 1; mode 1: random grant/ready; mode 2: grant dropped in RD2 of byte 2
    task automatic run_xfer(input logic [7:0] src, input logic [7:0] len, input int mode, input string tag);
        logic [7:0] exp [$];
        logic [7:0] st;
        int i = 0;
        for (int k = 0; k < int'(len); k++) exp.push_back(ram[8'(int'(src) + k)]);
        got.delete();
        stamps.delete();
        cpu_write(Base, src);
        cpu_write(Base + 8'd1, len);
        bus.bus_gnt   = 1'b1;
        bus.out_ready = 1'b1;
        cpu_write(Base + 8'd2, 8'h01);
        while (got.size() < int'(len) && i < 3000) begin
            case (mode)
                1: begin
                    bus.bus_gnt   = ($urandom_range(0, 3) != 0);
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                end
                2: bus.bus_gnt = !(i >= 6 && i < 9);
                default: begin
                    bus.bus_gnt   = 1'b1;
                    bus.out_ready = 1'b1;
                end
            endcase
            tick();
            i++;
        end
        check({tag, "_count"}, got.size(), {24'd0, len});
        for (int k = 0; k < got.size() && k < exp.size(); k++)
            check($sformatf("%s_byte%0d", tag, k), {24'd0, got[k]}, {24'd0, exp[k]});
        if (mode == 0)
            for (int k = 1; k < stamps.size(); k++)
                check($sformatf("%s_gap%0d", tag, k), stamps[k] - stamps[k-1], 32'd4);
        bus.out_ready = 1'b1;
        read_status(st);
        check({tag, "_status"}, {24'd0, st}, 32'h02);
    endtask

    initial begin
        logic [7:0] st;
        logic [7:0] held;
        bus.bus_addr  = 8'h00;
        bus.bus_we    = 1'b0;
        bus.bus_gnt   = 1'b0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 256; k++) ram[k] = 8'($urandom);
        repeat (3) tick();
        check("rst_req", {31'd0, bus.bus_req}, 32'd0);
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_data", {24'd0, bus.out_data}, 32'd0);
        check("rst_addr", {24'd0, bus.dma_addr}, 32'd0);
        RESET = 1'b0;
        read_status(st);
        check("rst_status", {24'd0, st}, 32'd0);

        // LEN=0 start: no request, done set
        cpu_write(Base + 8'd1, 8'd0);
        cpu_write(Base + 8'd2, 8'h01);
        for (int k = 0; k < 4; k++) begin
            check("len0_req", {31'd0, bus.bus_req}, 32'd0);
            tick();
        end
        read_status(st);
        check("len0_status", {24'd0, st}, 32'h02);

        ram[8'h10] = 8'hAA; ram[8'h11] = 8'hBB; ram[8'h12] = 8'hCC;
        run_xfer(8'h10, 8'd3, 0, "basic");
        ram[8'hFF] = 8'h11; ram[8'h00] = 8'h22;
        run_xfer(8'hFF, 8'd2, 0, "wrap");
        run_xfer(8'h40, 8'd4, 2, "gntdrop");

        // ready held low in PUSH
        cpu_write(Base, 8'h50);
        cpu_write(Base + 8'd1, 8'd2);
        got.delete();
        bus.bus_gnt   = 1'b1;
        bus.out_ready = 1'b0;
        cpu_write(Base + 8'd2, 8'h01);
        wait_valid("rdy_valid");
        held = bus.out_data;
        check("rdy_first", {24'd0, held}, {24'd0, ram[8'h50]});
        for (int k = 0; k < 10; k++) begin
            tick();
            check("rdy_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("rdy_hold_data", {24'd0, bus.out_data}, {24'd0, held});
            check("rdy_hold_req", {31'd0, bus.bus_req}, 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        check("rdy_accept", got.size(), 32'd1);
        check("rdy_after_valid", {31'd0, bus.out_valid}, 32'd0);
        wait_valid("rdy_valid2");
        tick();
        check("rdy_count", got.size(), 32'd2);
        if (got.size() == 2) check("rdy_second", {24'd0, got[1]}, {24'd0, ram[8'h51]});
        read_status(st);
        check("rdy_status", {24'd0, st}, 32'h02);

        // abort during PUSH of byte 1 of 5
        cpu_write(Base, 8'h60);
        cpu_write(Base + 8'd1, 8'd5);
        got.delete();
        bus.bus_gnt   = 1'b1;
        bus.out_ready = 1'b0;
        cpu_write(Base + 8'd2, 8'h01);
        wait_valid("abort_valid");
        cpu_write(Base + 8'd2, 8'h02);
        check("abort_valid_drop", {31'd0, bus.out_valid}, 32'd0);
        check("abort_req_drop", {31'd0, bus.bus_req}, 32'd0);
        read_status(st);
        check("abort_status", {24'd0, st}, 32'h04);
        check("abort_no_emit", got.size(), 32'd0);
        run_xfer(8'h70, 8'd3, 0, "restart");

        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 256; k++) ram[k] = 8'($urandom);
            run_xfer(8'($urandom), 8'($urandom_range(1, 8)), 1, $sformatf("rand%0d", t));
        end

        // reset mid-RD1
        cpu_write(Base, 8'h10);
        cpu_write(Base + 8'd1, 8'd3);
        bus.bus_gnt   = 1'b1;
        bus.out_ready = 1'b1;
        cpu_write(Base + 8'd2, 8'h01);
        tick();
        check("rd1_req", {31'd0, bus.bus_req}, 32'd1);
        check("rd1_addr", {24'd0, bus.dma_addr}, 32'h10);
        #2 RESET = 1'b1;
        #1;
        check("midrst_req", {31'd0, bus.bus_req}, 32'd0);
        check("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_data", {24'd0, bus.out_data}, 32'd0);
        check("midrst_addr", {24'd0, bus.dma_addr}, 32'd0);
        tick();
        RESET = 1'b0;
        bus.bus_gnt = 1'b0;
        read_status(st);
        check("midrst_status", {24'd0, st}, 32'd0);
        run_xfer(8'h20, 8'd2, 0, "postrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bus_dma_reader.md
BUS_DMA_READER -- requirements
Module: bus_dma_reader

Interface
REQ-001 Parameter DMABaseAddr, default 8'hC0, SHALL set the base of four bus-mapped registers: +0 SRC, +1 LEN, +2 CTRL, +3 STATUS.
REQ-002 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 BUS_DATA  inout  8  shared processor data bus; driven only for STATUS reads, else 8'hZZ.
REQ-005 BUS_ADDR  input  8  processor bus address, used for register decode.
REQ-006 BUS_WE  input  1  processor write strobe.
REQ-007 BUS_REQ  output  1  bus-mastership request to the processor.
REQ-008 BUS_GNT  input  1  bus grant; while high the top level routes DMA_ADDR onto the RAM address and holds RAM write-enable low.
REQ-009 DMA_ADDR  output  8  RAM read address, registered.
REQ-010 OUT_DATA  output  8  streamed byte.
REQ-011 OUT_VALID  output  1  OUT_DATA valid.
REQ-012 OUT_READY  input  1  downstream accepts the byte.

Function
REQ-013 Register write: BUS_WE=1 with BUS_ADDR=base+0 or base+1 SHALL load SRC or LEN on that edge, only in IDLE; writes while busy are ignored.
REQ-014 CTRL write: bit0=1 SHALL start a transfer from IDLE; bit1=1 SHALL abort from any non-IDLE state; abort takes priority when both bits are set.
REQ-015 STATUS read: BUS_WE=0 with BUS_ADDR=base+3 SHALL drive {5'b0, aborted, done, busy} on BUS_DATA in the following cycle, matching the RAM's one-cycle registered read timing; otherwise BUS_DATA=Z.
REQ-016 FSM states: IDLE, REQ, RD1, RD2, PUSH.
REQ-017 On start with LEN=0: stay IDLE, set done, clear aborted, make no bus request.
REQ-018 On start with LEN!=0: load cur_addr=SRC and count=LEN, clear done and aborted, go to REQ; busy=1 in all non-IDLE states.
REQ-019 REQ: assert BUS_REQ; on BUS_GNT=1 go to RD1.
REQ-020 BUS_REQ SHALL be 1 in REQ, RD1 and RD2, and 0 in IDLE and PUSH.
REQ-021 DMA_ADDR SHALL equal cur_addr in RD1 and RD2.
REQ-022 RD1 (RAM registers the address) -> RD2; at the end of RD2 (RAM drives data), capture BUS_DATA into OUT_DATA, set cur_addr+1 (8-bit wrap, 8'hFF->8'h00), set count-1, go to PUSH.
REQ-023 BUS_GNT=0 in RD1 or RD2 SHALL return to REQ with cur_addr and count unchanged, so the same byte is re-read.
REQ-024 PUSH: OUT_VALID=1 and OUT_DATA stable until OUT_READY=1 on a rising edge.
REQ-025 On acceptance, go to IDLE with done=1 if count=0, else go to REQ.
REQ-026 Throughput with continuous grant and ready: one byte per 4 cycles (REQ, RD1, RD2, PUSH).
REQ-027 Abort SHALL go to IDLE next edge, drop OUT_VALID and BUS_REQ, set aborted=1, leave done=0, and not emit the byte held in PUSH.
REQ-028 Start while busy (without abort) SHALL be ignored.

Reset
REQ-029 RESET=1 SHALL immediately force IDLE and set BUS_REQ=0, OUT_VALID=0, OUT_DATA=0, DMA_ADDR=0, SRC=0, LEN=0, count=0, STATUS=0, BUS_DATA=Z, including mid-transfer.
REQ-030 After RESET deasserts, the first edge SHALL accept register writes normally.

Verification
REQ-031 RAM[10..12]=AA,BB,CC, SRC=10, LEN=3, start, GNT and READY tied 1 -> OUT stream AA,BB,CC, one per 4 cycles, then STATUS=8'h02.
REQ-032 SRC=FF, LEN=2, RAM[FF]=11, RAM[00]=22 -> outputs 11 then 22 (address wrap).
REQ-033 GNT dropped for 3 cycles during RD2 of byte 2 of a 4-byte transfer -> byte 2 re-read, stream complete and in order, no duplicate or missed byte.
REQ-034 OUT_READY held low 10 cycles in PUSH -> OUT_VALID=1, OUT_DATA stable, BUS_REQ=0 throughout; byte accepted on the first edge with READY=1.
REQ-035 CTRL=8'h02 written during PUSH of byte 1 of 5 -> OUT_VALID=0 next cycle, STATUS=8'h04; a fresh start then works normally.
REQ-036 LEN=0 start -> no BUS_REQ, STATUS=8'h02 next read; RESET mid-RD1 -> all outputs at reset values immediately.
